// File: rtl/key_debounce.sv
// Two-channel active-low push-button synchroniser/debouncer emitting press pulses and held levels.
// Optional auto-repeat on held keys is built when KEY_REPEAT_EN is defined.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key0_n,
  input  logic key1_n,
  output logic k0,
  output logic k1,
  output logic held0,
  output logic held1
);

  typedef enum logic [3:0] {
    S_RELEASED    = 4'b0001,
    S_PRESS_CHK   = 4'b0010,
    S_PRESSED     = 4'b0100,
    S_RELEASE_CHK = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W) ||
      REPEAT_DELAY < 1 || 64'(REPEAT_DELAY) >= (64'd1 << CNT_W) ||
      REPEAT_PERIOD < 1 || 64'(REPEAT_PERIOD) >= (64'd1 << CNT_W)) begin : g_param_check
    $error("key_debounce: cycle parameter out of range for CNT_W");
  end

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       pressed;
  state_e           st_q   [2];
  state_e           st_d   [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] cnt_d  [2];
  logic [1:0]       k_q, k_d;
  logic [1:0]       held_q, held_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_cnt_q [2];
  logic [CNT_W-1:0] rep_cnt_d [2];
  logic [1:0]       rep_first_q, rep_first_d;
`endif

  assign pressed = ~sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      k_q     <= '0;
      held_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]  <= S_RELEASED;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {key1_n, key0_n};
      sync2_q <= sync1_q;
      k_q     <= k_d;
      held_q  <= held_d;
      for (int unsigned i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_first_q <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      rep_first_q <= rep_first_d;
      for (int unsigned i = 0; i < 2; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end
`endif

  always_comb begin
    k_d    = '0;
    held_d = '0;
`ifdef KEY_REPEAT_EN
    rep_first_d = '1;
`endif
    for (int unsigned i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        S_RELEASED: begin
          if (pressed[i]) begin
            st_d[i]  = S_PRESS_CHK;
            cnt_d[i] = '0;
          end
        end
        S_PRESS_CHK: begin
          if (!pressed[i]) begin
            st_d[i] = S_RELEASED;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i] = S_PRESSED;
            k_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!pressed[i]) begin
            st_d[i]  = S_RELEASE_CHK;
            cnt_d[i] = '0;
          end
        end
        S_RELEASE_CHK: begin
          if (pressed[i]) begin
            st_d[i] = S_PRESSED;
          end else if (cnt_q[i] == DB_LAST) begin
            st_d[i] = S_RELEASED;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          st_d[i]  = S_RELEASED;
          cnt_d[i] = '0;
        end
      endcase
      held_d[i] = (st_d[i] == S_PRESSED) || (st_d[i] == S_RELEASE_CHK);

`ifdef KEY_REPEAT_EN
      // Repeat timing runs only across edges that stay in PRESSED; any other path restarts the full delay.
      rep_cnt_d[i] = '0;
      if (st_q[i] == S_PRESSED && st_d[i] == S_PRESSED) begin
        rep_first_d[i] = rep_first_q[i];
        if (rep_cnt_q[i] == (rep_first_q[i] ? RD_LAST : RP_LAST)) begin
          k_d[i]         = 1'b1;
          rep_first_d[i] = 1'b0;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
`endif
    end
  end

  assign k0    = k_q[0];
  assign k1    = k_q[1];
  assign held0 = held_q[0];
  assign held1 = held_q[1];

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: run-length reference model compared every cycle,
// plus directed scenarios with hand-computed pulse/level edge positions.
module tb_key_debounce;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key0_n = 1'b1;
  logic key1_n = 1'b1;
  logic k0, k1, held0, held1;

  key_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key0_n(key0_n),
    .key1_n(key1_n),
    .k0    (k0),
    .k1    (k1),
    .held0 (held0),
    .held1 (held1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;
  int tb_edge = 0;

  always @(posedge clk) tb_edge <= tb_edge + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: a key flips its debounced level once DB+1 consecutive synchronised
  // samples disagree with it; repeats are timed from the latest entry to steady press.
  bit m_s1[2], m_s2[2], m_held[2], m_k[2];
  int m_run[2], m_entry[2];
  int m_edge = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1; m_s2[c] = 1; m_held[c] = 0; m_k[c] = 0;
        m_run[c] = 0; m_entry[c] = 0;
      end
    end else begin
      m_edge++;
      for (int c = 0; c < 2; c++) begin
        bit pr;
        pr = !m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = (c == 0) ? key0_n : key1_n;
        m_k[c] = 0;
        if (pr != m_held[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_held[c] = pr;
            m_run[c] = 0;
            if (pr) begin
              m_k[c] = 1;
              m_entry[c] = m_edge;
            end
          end
        end else begin
          if (m_held[c] && m_run[c] != 0) begin
            m_entry[c] = m_edge;
          end else if (m_held[c]) begin
`ifdef KEY_REPEAT_EN
            int age;
            age = m_edge - m_entry[c];
            if (age == RD || (age > RD && (age - RD) % RP == 0)) m_k[c] = 1;
`endif
          end
          m_run[c] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_k0", k0, m_k[0]);
      check("model_k1", k1, m_k[1]);
      check("model_held0", held0, m_held[0]);
      check("model_held1", held1, m_held[1]);
    end
  end

  int q0[$], q1[$], hr0[$], hf0[$];
  logic ph0 = 1'b0;

  always @(negedge clk) begin
    if (k0) q0.push_back(tb_edge);
    if (k1) q1.push_back(tb_edge);
    if (held0 === 1'b1 && ph0 === 1'b0) hr0.push_back(tb_edge);
    if (held0 === 1'b0 && ph0 === 1'b1) hf0.push_back(tb_edge);
    ph0 = held0;
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    q0.delete(); q1.delete(); hr0.delete(); hf0.delete();
  endtask

  initial begin
    int s, b, f, r;
    int exp_rep[$];

    #1 rst = 1'b1;
    started = 1;
    step(3);
    check("reset_k0", k0, 0);
    check("reset_k1", k1, 0);
    check("reset_held0", held0, 0);
    check("reset_held1", held1, 0);
    rst = 1'b0;
    step(10);

    // Clean press
    clear_logs();
    key0_n = 1'b0; s = tb_edge + 1;
    step(8);
    key0_n = 1'b1;
    step(14);
    check("clean_k0_count", q0.size(), 1);
    check("clean_k0_edge", qat(q0, 0), s + 6);
    check("clean_held0_rise", qat(hr0, 0), s + 6);
    check("clean_held0_fall", qat(hf0, 0), s + 14);
    check("clean_k1_count", q1.size(), 0);

    // Press bounce
    clear_logs();
    key0_n = 1'b0;
    step(2);
    key0_n = 1'b1;
    step(1);
    key0_n = 1'b0; b = tb_edge + 1;
    step(10);
    key0_n = 1'b1;
    step(16);
    check("pbounce_k0_count", q0.size(), 1);
    check("pbounce_k0_edge", qat(q0, 0), b + 6);

    // Release bounce
    clear_logs();
    key0_n = 1'b0; s = tb_edge + 1;
    step(8);
    key0_n = 1'b1;
    step(2);
    key0_n = 1'b0;
    step(1);
    key0_n = 1'b1; f = tb_edge + 1;
    step(14);
    check("rbounce_k0_count", q0.size(), 1);
    check("rbounce_k0_edge", qat(q0, 0), s + 6);
    check("rbounce_held0_fall_count", hf0.size(), 1);
    check("rbounce_held0_fall", qat(hf0, 0), f + 6);

    // Simultaneous press
    clear_logs();
    key0_n = 1'b0; key1_n = 1'b0; s = tb_edge + 1;
    step(8);
    key0_n = 1'b1; key1_n = 1'b1;
    step(14);
    check("simul_k0_count", q0.size(), 1);
    check("simul_k1_count", q1.size(), 1);
    check("simul_k0_edge", qat(q0, 0), s + 6);
    check("simul_k1_edge", qat(q1, 0), s + 6);

    // Reset during press qualification, key held throughout
    clear_logs();
    key0_n = 1'b0;
    step(5);
    rst = 1'b1;
    step(1);
    check("rstmid_k0", k0, 0);
    check("rstmid_held0", held0, 0);
    step(2);
    check("rstmid_k0_late", k0, 0);
    check("rstmid_held0_late", held0, 0);
    rst = 1'b0; r = tb_edge;
    step(12);
    key0_n = 1'b1;
    step(14);
    check("rstmid_k0_count", q0.size(), 1);
    check("rstmid_k0_edge", qat(q0, 0), r + 7);

    // Long hold on key 1
    clear_logs();
`ifdef KEY_REPEAT_EN
    exp_rep = '{6, 16, 19, 22, 25, 28, 31};
`else
    exp_rep = '{6};
`endif
    key1_n = 1'b0; s = tb_edge + 1;
    step(30);
    key1_n = 1'b1;
    step(16);
    check("hold_k1_count", q1.size(), exp_rep.size());
    for (int i = 0; i < exp_rep.size(); i++) begin
      check($sformatf("hold_k1_edge%0d", i), qat(q1, i), s + exp_rep[i]);
    end
    check("hold_k0_count", q0.size(), 0);

    // Randomised bouncing on both keys with occasional resets
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 2) == 0) key0_n = ~key0_n;
      if ($urandom_range(0, 2) == 0) key1_n = ~key1_n;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      step($urandom_range(1, 9));
    end
    key0_n = 1'b1; key1_n = 1'b1;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
